// File: rtl/serial_pair_serializer_if.sv
// Handshake bundle for serial_pair_serializer: a word-wide operand-pair input
// stream and a one-bit-pair output stream with first/last framing.
interface serial_pair_serializer_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic             out_a;
  logic             out_b;
  logic             out_first;
  logic             out_last;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_first, out_last
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_a, out_b, out_first, out_last
  );
endinterface

// File: rtl/serial_pair_serializer.sv
// Streams an (a, b) operand pair one bit-pair per cycle with first/last framing,
// with a one-deep pending word. Optional synchronous abort: SERIAL_PAIR_SERIALIZER_ABORT_EN.
module serial_pair_serializer #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic clk,
  input logic rst,
`ifdef SERIAL_PAIR_SERIALIZER_ABORT_EN
  input logic i_abort,
`endif
  serial_pair_serializer_if.slave bus
);

  // state | meaning
  // IDLE  | shifter empty, no bit-pair presented
  // SHIFT | shifter holds a word, r_cnt bit-pairs of it already sent
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift_a, r_shift_b, w_shift_a_nxt, w_shift_b_nxt;
  logic [WIDTH-1:0] r_pend_a, r_pend_b, w_pend_a_nxt, w_pend_b_nxt;
  logic             r_pend_full, w_pend_full_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;

  logic w_valid, w_last, w_in_xfer, w_out_xfer, w_in_used;

  assign w_valid    = (r_state == ST_SHIFT);
  assign w_last     = (r_cnt == C_LAST);
  assign w_in_xfer  = bus.in_valid & ~r_pend_full;
  assign w_out_xfer = w_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_shift_a   <= '0;
      r_shift_b   <= '0;
      r_pend_a    <= '0;
      r_pend_b    <= '0;
      r_pend_full <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift_a   <= w_shift_a_nxt;
      r_shift_b   <= w_shift_b_nxt;
      r_pend_a    <= w_pend_a_nxt;
      r_pend_b    <= w_pend_b_nxt;
      r_pend_full <= w_pend_full_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_shift_a_nxt   = r_shift_a;
    w_shift_b_nxt   = r_shift_b;
    w_pend_a_nxt    = r_pend_a;
    w_pend_b_nxt    = r_pend_b;
    w_pend_full_nxt = r_pend_full;
    w_cnt_nxt       = r_cnt;
    w_in_used       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_in_xfer) begin
          w_shift_a_nxt = bus.in_a;
          w_shift_b_nxt = bus.in_b;
          w_cnt_nxt     = '0;
          w_in_used     = 1'b1;
          w_state_nxt   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_out_xfer) begin
          if (w_last) begin
            w_cnt_nxt = '0;
            // Refill straight from pending or the input so words run back-to-back.
            if (r_pend_full) begin
              w_shift_a_nxt   = r_pend_a;
              w_shift_b_nxt   = r_pend_b;
              w_pend_full_nxt = 1'b0;
            end else if (w_in_xfer) begin
              w_shift_a_nxt = bus.in_a;
              w_shift_b_nxt = bus.in_b;
              w_in_used     = 1'b1;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            if (MSB_FIRST) begin
              w_shift_a_nxt = {r_shift_a[WIDTH-2:0], 1'b0};
              w_shift_b_nxt = {r_shift_b[WIDTH-2:0], 1'b0};
            end else begin
              w_shift_a_nxt = {1'b0, r_shift_a[WIDTH-1:1]};
              w_shift_b_nxt = {1'b0, r_shift_b[WIDTH-1:1]};
            end
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_in_xfer && !w_in_used) begin
      w_pend_a_nxt    = bus.in_a;
      w_pend_b_nxt    = bus.in_b;
      w_pend_full_nxt = 1'b1;
    end

`ifdef SERIAL_PAIR_SERIALIZER_ABORT_EN
    if (i_abort) begin
      w_state_nxt     = ST_IDLE;
      w_shift_a_nxt   = '0;
      w_shift_b_nxt   = '0;
      w_pend_a_nxt    = '0;
      w_pend_b_nxt    = '0;
      w_pend_full_nxt = 1'b0;
      w_cnt_nxt       = '0;
    end
`endif
  end

  // Data bits are gated by valid so stale shifter contents never leak out in IDLE.
  assign bus.in_ready  = ~r_pend_full;
  assign bus.out_valid = w_valid;
  assign bus.out_a     = w_valid & (MSB_FIRST ? r_shift_a[WIDTH-1] : r_shift_a[0]);
  assign bus.out_b     = w_valid & (MSB_FIRST ? r_shift_b[WIDTH-1] : r_shift_b[0]);
  assign bus.out_first = w_valid & (r_cnt == '0);
  assign bus.out_last  = w_valid & w_last;

endmodule

// File: tb/tb_serial_pair_serializer.sv
// Scoreboard bench: MSB-first and LSB-first instances driven with identical stimulus,
// each checked by its own monitor against an expected bit-pair queue.
module tb_serial_pair_serializer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_ready;
`ifdef SERIAL_PAIR_SERIALIZER_ABORT_EN
  logic        abort;
`endif

  int n_tests;
  int n_fail;

  logic [3:0] q_m[$];
  logic [3:0] q_l[$];

  serial_pair_serializer_if #(.WIDTH(16)) if_m ();
  serial_pair_serializer_if #(.WIDTH(16)) if_l ();

  assign if_m.in_valid  = in_valid;
  assign if_m.in_a      = in_a;
  assign if_m.in_b      = in_b;
  assign if_m.out_ready = out_ready;
  assign if_l.in_valid  = in_valid;
  assign if_l.in_a      = in_a;
  assign if_l.in_b      = in_b;
  assign if_l.out_ready = out_ready;

  serial_pair_serializer #(.WIDTH(16), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk),
    .rst(rst),
`ifdef SERIAL_PAIR_SERIALIZER_ABORT_EN
    .i_abort(abort),
`endif
    .bus(if_m)
  );

  serial_pair_serializer #(.WIDTH(16), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk),
    .rst(rst),
`ifdef SERIAL_PAIR_SERIALIZER_ABORT_EN
    .i_abort(abort),
`endif
    .bus(if_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected element: {a, b, first, last}
  task automatic push_word(input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < 16; i++) begin
      q_m.push_back({a[15-i], b[15-i], i == 0, i == 15});
      q_l.push_back({a[i], b[i], i == 0, i == 15});
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] e;
    if (if_m.out_valid && out_ready) begin
      if (q_m.size() == 0) check("m_unexpected_beat", 32'(1), 32'(0));
      else begin
        e = q_m.pop_front();
        check("m_beat", 32'({if_m.out_a, if_m.out_b, if_m.out_first, if_m.out_last}), 32'(e));
      end
    end else if (!if_m.out_valid) begin
      check("m_idle_flags", 32'({if_m.out_first, if_m.out_last}), 32'(0));
    end
  end

  always @(negedge clk) begin
    logic [3:0] e;
    if (if_l.out_valid && out_ready) begin
      if (q_l.size() == 0) check("l_unexpected_beat", 32'(1), 32'(0));
      else begin
        e = q_l.pop_front();
        check("l_beat", 32'({if_l.out_a, if_l.out_b, if_l.out_first, if_l.out_last}), 32'(e));
      end
    end else if (!if_l.out_valid) begin
      check("l_idle_flags", 32'({if_l.out_first, if_l.out_last}), 32'(0));
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int n;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    n        = 0;
    @(negedge clk);
    while (!(if_m.in_ready && if_l.in_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_timeout", 32'(n < 100), 32'(1));
    push_word(a, b);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_m.size() != 0 || q_l.size() != 0 || if_m.out_valid || if_l.out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(n < 200), 32'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string name);
    check(name, 32'({if_m.out_valid, if_m.out_a, if_m.out_b, if_m.out_first, if_m.out_last, if_m.in_ready,
                     if_l.out_valid, if_l.out_a, if_l.out_b, if_l.out_first, if_l.out_last, if_l.in_ready}),
          32'(12'b000001_000001));
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
`ifdef SERIAL_PAIR_SERIALIZER_ABORT_EN
    abort     = 1'b0;
`endif
    #2;
    check_cleared("reset_state");
    #10 rst = 1'b1;
    @(posedge clk);
    #1;

    // Single word, both orders; 16 contiguous beats then idle.
    send(16'h6482, 16'h6262);
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      check("single_valid", 32'({if_m.out_valid, if_l.out_valid}), (k <= 15) ? 32'(2'b11) : 32'(2'b00));
    end
    drain();

    // Back-to-back: second word lands in pending, no bubble between words.
    send(16'hFFFF, 16'h0000);
    send(16'h0001, 16'h0001);
    check("b2b_ready_low", 32'({if_m.in_ready, if_l.in_ready}), 32'(0));
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      check("b2b_valid", 32'({if_m.out_valid, if_l.out_valid}), (k <= 31) ? 32'(2'b11) : 32'(2'b00));
      if (k == 15) check("b2b_ready_held", 32'({if_m.in_ready, if_l.in_ready}), 32'(0));
      if (k == 16) check("b2b_word2_start", 32'({if_m.in_ready, if_l.in_ready, if_m.out_first, if_l.out_first}),
                         32'(4'b1111));
    end
    drain();

    // Stall three cycles while bit 5 is presented.
    begin
      logic [15:0] sa;
      logic [15:0] sb;
      sa = 16'hA5C3;
      sb = 16'h3C5A;
      send(sa, sb);
      repeat (5) @(posedge clk);
      #1 out_ready = 1'b0;
      repeat (3) begin
        @(negedge clk);
        check("stall_hold_m", 32'({if_m.out_valid, if_m.out_a, if_m.out_b, if_m.out_first, if_m.out_last}),
              32'({1'b1, sa[10], sb[10], 2'b00}));
        check("stall_hold_l", 32'({if_l.out_valid, if_l.out_a, if_l.out_b, if_l.out_first, if_l.out_last}),
              32'({1'b1, sa[5], sb[5], 2'b00}));
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      drain();
    end

    // Reset mid-word (bit 9) with pending full.
    send(16'h1234, 16'h5678);
    send(16'h9ABC, 16'hDEF0);
    repeat (8) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check_cleared("midword_reset");
    q_m.delete();
    q_l.delete();
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    send(16'h8000, 16'h7FFF);
    drain();

`ifdef SERIAL_PAIR_SERIALIZER_ABORT_EN
    send(16'hC3A5, 16'h0F0F);
    send(16'h1111, 16'h2222);
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    q_m.delete();
    q_l.delete();
    check_cleared("abort_clear");
    send(16'hBEEF, 16'h4321);
    drain();
`endif

    check("queues_empty", 32'(q_m.size() + q_l.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_pair_serializer.md
Name: serial_pair_serializer

Overview:
- Upstream stage for the serial comparators.
- Accepts a pair of WIDTH-bit operands (a, b) over a valid/ready handshake and streams them one bit-pair per cycle.
- Order is MSB-first or LSB-first, selected by parameter, with first/last framing flags so the downstream comparator can restart its state per word.
- A one-deep pending buffer allows back-to-back words with no bubble cycles.

Parameters:
- WIDTH, 16: operand width in bits; legal range 2..64.
- MSB_FIRST, 1: 1 = emit bit WIDTH-1 first; 0 = emit bit 0 first.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand pair on in_a/in_b is valid.
- in_ready  output  1  block can accept an operand pair this cycle.
- in_a  input  WIDTH  operand a.
- in_b  input  WIDTH  operand b.
- out_valid  output  1  out_a/out_b carry a valid bit-pair.
- out_ready  input  1  downstream consumes the bit-pair this cycle.
- out_a  output  1  current bit of a.
- out_b  output  1  current bit of b.
- out_first  output  1  high with the first bit-pair of a word.
- out_last  output  1  high with the final bit-pair of a word.

Behaviour:
- Reset (rst=0, async): all registers clear.
  - out_valid, out_a, out_b, out_first, out_last = 0.
  - in_ready = 1; state = IDLE; pending buffer empty; bit counter = 0.
- Input transfer: in_valid & in_ready at a rising edge.
- Output transfer: out_valid & out_ready at a rising edge.
- All outputs are registered or decoded from registers only; no combinational path from in_* or out_ready to out_*.
- in_ready = ~pend_full. It does not depend on in_valid or out_ready in the same cycle.
- State IDLE (shifter empty):
  - An input transfer loads the shifter directly.
  - Next cycle: state SHIFT, out_valid=1, out_first=1. Latency is 1 cycle from accept to first bit.
- State SHIFT:
  - out_a/out_b show the current bit (MSB_FIRST picks the end); bit counter = bits already sent.
  - out_first = (counter==0); out_last = (counter==WIDTH-1).
  - On an output transfer with out_last=0: shift one position, counter+1.
  - On an output transfer with out_last=1, the word completes:
    - pending full: load pending into shifter, clear pending, counter=0, stay SHIFT. The next cycle shows the first bit of the new word (no bubble).
    - pending empty with a simultaneous input transfer: load the input directly into the shifter, stay SHIFT.
    - pending empty, no input transfer: go IDLE, out_valid=0.
  - An input transfer in SHIFT not consumed by the completion rule fills pending.
- Stall: out_ready=0 holds out_a, out_b, out_first, out_last and out_valid unchanged.
- Throughput: one bit-pair per cycle sustained; one word per WIDTH cycles when out_ready is constantly 1.
- Reset asserted mid-word discards the shifter and pending contents immediately. After release, the block accepts a fresh word from IDLE.
- out_valid is never 1 in IDLE; out_first and out_last are 0 whenever out_valid=0.

Optional Feature:
- Macro: SERIAL_PAIR_SERIALIZER_ABORT_EN.
- When defined: adds input port abort (1 bit, synchronous, active-high).
  - abort=1 at a rising edge clears shifter, pending and counter; state goes IDLE; out_valid=0 next cycle.
  - Any input transfer in the same cycle is dropped. in_ready=1 the following cycle.
  - abort has priority over all other events except rst.
- When not defined: no abort port; words can only be cancelled by rst.

Test Plan:
- MSB_FIRST=1, WIDTH=16, in_a=16'h6482, in_b=16'h6262, out_ready=1.
  -> out_a stream 0110_0100_1000_0010 and out_b stream 0110_0010_0110_0010 over 16 consecutive cycles.
  -> out_first on cycle 1 only, out_last on cycle 16 only, out_valid=0 on cycle 17.
- Same word with MSB_FIRST=0.
  -> out_a stream 0100_0001_0010_0110 (bit 0 first); framing identical.
- Back-to-back: words 16'hFFFF/16'h0000 then 16'h0001/16'h0001 offered consecutively, out_ready=1.
  -> in_ready drops after the second accept and returns when word 2 starts.
  -> 32 contiguous valid cycles; out_first on cycles 1 and 17.
- Stall: out_ready=0 for 3 cycles while bit 5 is presented.
  -> out_a/out_b/out_valid unchanged for those 3 cycles; bit 6 appears 1 cycle after out_ready returns high.
- Reset: rst=0 asserted mid-cycle at bit 9 of a word with pending full.
  -> all outputs 0 immediately, in_ready=1.
  -> after release, a new word 16'h8000/16'h7FFF streams with out_first on its first bit.
- ABORT_EN: abort=1 at bit 3 of a word.
  -> out_valid=0 next cycle, pending discarded, the next accepted word streams from bit 0.
